// File: rtl/blackjack_pkg.sv
// blackjack_pkg: state encoding, result codes, default limits and card legality
// check shared by the blackjack controller and its hand accumulators.
package blackjack_pkg;

  localparam int DEALER_STAND_DEF = 17;
  localparam int HAND_LIMIT_DEF   = 21;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_DEAL_P1 = 4'd1;
  localparam state_t ST_DEAL_D1 = 4'd2;
  localparam state_t ST_DEAL_P2 = 4'd3;
  localparam state_t ST_DEAL_D2 = 4'd4;
  localparam state_t ST_PLAYER  = 4'd5;
  localparam state_t ST_P_DRAW  = 4'd6;
  localparam state_t ST_DEALER  = 4'd7;
  localparam state_t ST_D_DRAW  = 4'd8;
  localparam state_t ST_RESOLVE = 4'd9;
  localparam state_t ST_DONE    = 4'd10;

  typedef logic [1:0] result_t;

  localparam result_t RES_NONE = 2'b00;
  localparam result_t RES_WIN  = 2'b01;
  localparam result_t RES_LOSE = 2'b10;
  localparam result_t RES_PUSH = 2'b11;

  // Cards from the draw unit are only meaningful in the range 1..10.
  function automatic logic card_is_legal(input logic [3:0] card);
    return (card >= 4'd1) && (card <= 4'd10);
  endfunction

endpackage

// File: rtl/blackjack_ctrl_hand_accum.sv
// hand_accum: running total of one hand. Keeps the hard total and an ace flag;
// the reported total adds 10 for a usable ace only when SOFT_ACE_EN is defined.
// Also exposes the total the hand would report if the offered card were added,
// so the sequencer can decide its next state on the accepting edge.
module hand_accum
  import blackjack_pkg::*;
#(
  parameter int HAND_LIMIT = HAND_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] card,
  output logic [4:0] total,
  output logic [4:0] total_if_add,
  output logic       bust
);

`ifdef SOFT_ACE_EN
  localparam logic SOFT_ACE = 1'b1;
`else
  localparam logic SOFT_ACE = 1'b0;
`endif

  logic [4:0] hard_q, hard_d;
  logic       ace_q, ace_d;
  logic [4:0] hard_plus;
  logic       ace_plus;

  function automatic logic [4:0] reported(input logic [4:0] hard, input logic ace);
    if (SOFT_ACE && ace && (hard <= 5'(HAND_LIMIT - 10))) return hard + 5'd10;
    return hard;
  endfunction

  assign hard_plus    = hard_q + 5'(card);
  assign ace_plus     = ace_q | (card == 4'd1);
  assign total        = reported(hard_q, ace_q);
  assign total_if_add = reported(hard_plus, ace_plus);
  assign bust         = total > 5'(HAND_LIMIT);

  // Next hard total / ace flag: clear wins over add.
  always_comb begin
    hard_d = hard_q;
    ace_d  = ace_q;
    if (clear) begin
      hard_d = 5'd0;
      ace_d  = 1'b0;
    end else if (add) begin
      hard_d = hard_plus;
      ace_d  = ace_plus;
    end
  end

  // Hand registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      hard_q <= 5'd0;
      ace_q  <= 1'b0;
    end else begin
      hard_q <= hard_d;
      ace_q  <= ace_d;
    end
  end

endmodule

// File: rtl/blackjack_ctrl.sv
// blackjack_ctrl: sequences one game of player vs dealer through a card-draw
// handshake. Soft-ace scoring is enabled by defining SOFT_ACE_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// DEAL_P1 | first player card requested
// DEAL_D1 | first dealer card requested
// DEAL_P2 | second player card requested
// DEAL_D2 | second dealer card requested
// PLAYER  | waiting for hit or stand
// P_DRAW  | player hit card requested
// DEALER  | one-cycle decision: draw or resolve
// D_DRAW  | dealer card requested
// RESOLVE | compute result
// DONE    | result valid, waiting for start
module blackjack_ctrl
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = DEALER_STAND_DEF,
  parameter int HAND_LIMIT   = HAND_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  output logic       draw_req,
  output logic       turn,
  input  logic [3:0] card_in,
  input  logic       card_valid,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [1:0] result,
  output logic       done,
  output logic       err
);

  state_t     state_q, state_d;
  result_t    result_q, result_d;
  logic       err_q, err_d;
  logic       new_game, in_draw, card_good, card_bad, p_add, d_add;
  logic [4:0] p_next, d_next;
  logic       p_bust, d_bust;
  logic       unused_dealer_next;

  assign new_game  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_draw   = state_q inside {ST_DEAL_P1, ST_DEAL_D1, ST_DEAL_P2, ST_DEAL_D2,
                                     ST_P_DRAW, ST_D_DRAW};
  assign card_good = in_draw && card_valid && card_is_legal(card_in);
  assign card_bad  = in_draw && card_valid && !card_is_legal(card_in);
  assign p_add     = card_good && (state_q inside {ST_DEAL_P1, ST_DEAL_P2, ST_P_DRAW});
  assign d_add     = card_good && (state_q inside {ST_DEAL_D1, ST_DEAL_D2, ST_D_DRAW});

  hand_accum #(.HAND_LIMIT(HAND_LIMIT)) u_player (
    .clock        (clock),
    .reset        (reset),
    .clear        (new_game),
    .add          (p_add),
    .card         (card_in),
    .total        (player_total),
    .total_if_add (p_next),
    .bust         (p_bust)
  );

  hand_accum #(.HAND_LIMIT(HAND_LIMIT)) u_dealer (
    .clock        (clock),
    .reset        (reset),
    .clear        (new_game),
    .add          (d_add),
    .card         (card_in),
    .total        (dealer_total),
    .total_if_add (d_next),
    .bust         (d_bust)
  );

  // The dealer's decision is re-evaluated in DEALER, so its look-ahead is not needed.
  assign unused_dealer_next = ^d_next;

  // Next-state, result and error decisions; an illegal card overrides everything.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_DEAL_P1;
          result_d = RES_NONE;
          err_d    = 1'b0;
        end
      end
      ST_DEAL_P1: if (card_good) state_d = ST_DEAL_D1;
      ST_DEAL_D1: if (card_good) state_d = ST_DEAL_P2;
      ST_DEAL_P2: if (card_good) state_d = ST_DEAL_D2;
      ST_DEAL_D2: begin
        if (card_good)
          state_d = (player_total == 5'(HAND_LIMIT)) ? ST_DEALER : ST_PLAYER;
      end
      ST_PLAYER: begin
        if (stand)    state_d = ST_DEALER;
        else if (hit) state_d = ST_P_DRAW;
      end
      ST_P_DRAW: begin
        if (card_good) begin
          if (p_next > 5'(HAND_LIMIT))       state_d = ST_RESOLVE;
          else if (p_next == 5'(HAND_LIMIT)) state_d = ST_DEALER;
          else                               state_d = ST_PLAYER;
        end
      end
      ST_DEALER: state_d = (dealer_total < 5'(DEALER_STAND)) ? ST_D_DRAW : ST_RESOLVE;
      ST_D_DRAW: if (card_good) state_d = ST_DEALER;
      ST_RESOLVE: begin
        if (p_bust)                           result_d = RES_LOSE;
        else if (d_bust)                      result_d = RES_WIN;
        else if (player_total > dealer_total) result_d = RES_WIN;
        else if (player_total < dealer_total) result_d = RES_LOSE;
        else                                  result_d = RES_PUSH;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (card_bad) begin
      err_d    = 1'b1;
      result_d = RES_NONE;
      state_d  = ST_DONE;
    end
  end

  // Controller registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= RES_NONE;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign draw_req = in_draw;
  assign turn     = state_q inside {ST_DEAL_D1, ST_DEAL_D2, ST_D_DRAW, ST_DEALER};
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign err      = err_q;

endmodule

// File: doc/blackjack_ctrl.md
BLACKJACK_CTRL -- requirements
Module: blackjack_ctrl

Interface
REQ-001 SHALL have parameter DEALER_STAND, default 17, meaning the dealer stops drawing when its total is at least this value.
REQ-002 SHALL have parameter HAND_LIMIT, default 21, meaning the highest non-bust total.
REQ-003 SHALL have port clock, input, 1, system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that begins a new game.
REQ-006 SHALL have port hit, input, 1, single-cycle pulse for a player draw request.
REQ-007 SHALL have port stand, input, 1, single-cycle pulse that ends the player's turn.
REQ-008 SHALL have port draw_req, output, 1, request to the card-draw unit.
REQ-009 SHALL have port turn, output, 1, 0 = player, 1 = dealer; selects the card range of the draw unit.
REQ-010 SHALL have port card_in, input, 4, card value returned by the draw unit.
REQ-011 SHALL have port card_valid, input, 1, card_in is valid this cycle.
REQ-012 SHALL have port player_total, output, 5, player hand total.
REQ-013 SHALL have port dealer_total, output, 5, dealer hand total.
REQ-014 SHALL have port result, output, 2, game result: 00 none, 01 win, 10 lose, 11 push.
REQ-015 SHALL have port done, output, 1, game finished; result is valid.
REQ-016 SHALL have port err, output, 1, protocol error latched.

Function
REQ-017 SHALL implement these states: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER, P_DRAW, DEALER, D_DRAW, RESOLVE, DONE.
REQ-018 SHALL move from IDLE or DONE to DEAL_P1 on start, clearing the totals, result, done and err; start SHALL be ignored in all other states.
REQ-019 SHALL use this draw handshake: in every DEAL_*, P_DRAW and D_DRAW state, draw_req is held high until a cycle with card_valid=1.
REQ-020 SHALL accept the card in that cycle, update the total on the next edge, and deassert draw_req in the same edge.
REQ-021 SHALL drive turn to 0 in DEAL_P*/P_DRAW/PLAYER, 1 in DEAL_D*/D_DRAW/DEALER, and 0 elsewhere.
REQ-022 SHALL treat a card_in value outside 1..10 while card_valid=1 as an error: set err, result=00, go to DONE.
REQ-023 SHALL run the deal order P, D, P, D, then go to PLAYER; if player_total equals HAND_LIMIT it SHALL go directly to DEALER.
REQ-024 SHALL, in PLAYER: on stand go to DEALER; on hit go to P_DRAW; if hit and stand occur in the same cycle, stand wins.
REQ-025 SHALL, after a P_DRAW card: go to RESOLVE if total > HAND_LIMIT; go to DEALER if total == HAND_LIMIT; otherwise return to PLAYER.
REQ-026 SHALL, in DEALER: go to D_DRAW if dealer_total < DEALER_STAND, else go to RESOLVE (one-cycle evaluation).
REQ-027 SHALL, in RESOLVE, set result by this priority: player bust = lose; dealer bust = win; player > dealer = win; player < dealer = lose; equal = push. It SHALL then go to DONE.
REQ-028 SHALL hold done=1 and result stable in DONE until start or reset.
REQ-029 SHALL compute totals at 5-bit width with no wrap; maximum is 31 (21+10).

Reset
REQ-030 SHALL, on reset: state=IDLE; draw_req=0, turn=0, totals=0, result=00, done=0, err=0.
REQ-031 SHALL, on reset during a draw handshake, drop draw_req in the same edge and discard any card_valid in that cycle.

Configuration
REQ-032 SHALL support macro SOFT_ACE_EN. When defined, a hand containing an ace whose hard total is at most HAND_LIMIT-10 reports hard total + 10, and all comparisons use the reported total. When undefined, an ace counts only as 1.

Structure
REQ-033 SHALL put the state enum, result codes, and default limit constants in shared package blackjack_pkg.
REQ-034 SHALL contain sub-module hand_accum, instantiated twice (player and dealer), holding the hard total, ace flag, reported total and bust flag, with clear and add ports.

Verification
REQ-035 SHALL cover: deal of cards 10,5,9,6 with stand -> player 19, dealer 11; dealer draws until >=17; with dealer card 8, dealer = 19 -> result=11.
REQ-036 SHALL cover: player 10,6, hit gives 9 -> player 25, goes straight to RESOLVE with no dealer draw, result=10.
REQ-037 SHALL cover: card_valid held low 5 cycles -> draw_req stays high all 5 cycles; totals unchanged.
REQ-038 SHALL cover: hit and stand in the same cycle -> goes to DEALER; no P_DRAW entered.
REQ-039 SHALL cover: SOFT_ACE_EN defined, player 1,10 -> player_total 21, auto-moves to DEALER; without the macro -> total 11, stays in PLAYER.
REQ-040 SHALL cover: card_in=0 with card_valid=1 -> err=1, done=1, result=00; also reset mid-D_DRAW -> all outputs return to their reset values the next cycle.
